// File: rtl/muldiv_seq.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO register pair.
// It computes one bit per cycle: 32 ITER cycles, then one FIX cycle that sign-corrects the result and writes HI/LO.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic [31:0] a_orig;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] prod;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    // Unsigned ops pass straight through; 0x80000000 maps onto itself.
    function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
        logic signed [31:0] s;
        s = x;
        return (sgn && s < 0) ? 32'(-s) : x;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : 33'd0);
        div_shift = {acc_hi, acc_lo[31]};
        div_ge    = div_shift >= {1'b0, mag_b};
        // The remainder always stays below the divisor, so 32 bits hold the difference.
        div_diff  = div_shift[31:0] - mag_b;
        prod      = {acc_hi, acc_lo};
        fix_hi    = acc_hi;
        fix_lo    = acc_lo;
        if (div_zero) begin
            fix_hi = a_orig;
            fix_lo = 32'hFFFF_FFFF;
        end else if (is_div) begin
            fix_hi = neg_r ? neg32(acc_hi) : acc_hi;
            fix_lo = neg_q ? neg32(acc_lo) : acc_lo;
        end else if (neg_q) begin
            {fix_hi, fix_lo} = neg64(prod);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            a_orig   <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !abort) begin
                        state    <= ITER;
                        busy     <= 1'b1;
                        cnt      <= 5'd31;
                        is_div   <= op[1];
                        neg_q    <= !op[0] && (a[31] ^ b[31]);
                        neg_r    <= !op[0] && a[31];
                        div_zero <= op[1] && (b == 32'd0);
                        a_orig   <= a;
                        mag_a    <= abs32(a, !op[0]);
                        mag_b    <= abs32(b, !op[0]);
                        acc_hi   <= '0;
                        // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier.
                        acc_lo   <= op[1] ? abs32(a, !op[0]) : abs32(b, !op[0]);
                    end
                end
                ITER: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (is_div) begin
                            acc_hi <= div_ge ? div_diff : div_shift[31:0];
                            acc_lo <= {acc_lo[30:0], div_ge};
                        end else begin
                            acc_hi <= mul_sum[32:1];
                            acc_lo <= {mul_sum[0], acc_lo[31:1]};
                        end
                        if (cnt == 5'd0) state <= FIX;
                        else             cnt   <= cnt - 5'd1;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!abort) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq, with a plain-arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        abort = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Result {hi,lo} from the instruction set semantics using wide integers.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'd0: p = sx * sy;
            2'd1: p = {32'd0, x} * {32'd0, y};
            2'd2: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
            default: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
        endcase
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (busy && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp);
        int cyc;
        launch(o, x, y);
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        wait_done(0, cyc);
        check({tag, "_cycles"}, 64'(cyc), 64'd33);
        check({tag, "_res"}, {hi, lo}, exp);
    endtask

    initial begin
        int cyc;
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        logic [63:0] saved;

        tick();
        check("reset_state", {hi, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        tick();

        run_op("mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_minint", 2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("div_neg7by2", 2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_100by7", 2'd3, 32'd100, 32'd7, {32'd2, 32'd14});
        run_op("div_minint_m1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        run_op("divu_by0", 2'd3, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF});
        run_op("div_by0_neg", 2'd2, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF});

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = (i % 9 == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: ry = 32'd1;
                2: ry = 32'hFFFF_FFFF;
                3: ry = 32'h8000_0000;
                4: ry = $urandom_range(1, 100);
                default: ry = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), ro, rx, ry, ref_model(ro, rx, ry));
        end

        // MTHI / MTLO while idle, then an aborted MULTU leaves them intact.
        hi_we = 1'b1; wdata = 32'hAAAA; tick(); hi_we = 1'b0;
        lo_we = 1'b1; wdata = 32'h5555; tick(); lo_we = 1'b0;
        check("mt_preload", {hi, lo}, {32'hAAAA, 32'h5555});
        launch(2'd1, 32'd3, 32'd4);
        repeat (10) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, {32'hAAAA, 32'h5555});
        repeat (3) tick();
        check("abort_stays_idle", {63'd0, busy}, 64'd0);

        // Abort together with start while idle: nothing launches.
        abort = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_start_idle", {63'd0, busy}, 64'd0);
        repeat (40) tick();
        check("abort_start_hilo", {hi, lo}, {32'hAAAA, 32'h5555});

        // Second start and MT writes during busy are dropped.
        launch(2'd1, 32'd6, 32'd7);
        repeat (5) tick();
        op = 2'd3; a = 32'd100; b = 32'd3; start = 1'b1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
        tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("busy_mt_dropped", {hi, lo}, {32'hAAAA, 32'h5555});
        wait_done(6, cyc);
        check("restart_cycles", 64'(cyc), 64'd33);
        check("restart_res", {hi, lo}, {32'd0, 32'd42});

        // MT write in the same cycle as start commits, then the result overwrites.
        hi_we = 1'b1; wdata = 32'h1111;
        op = 2'd1; a = 32'd2; b = 32'd3; start = 1'b1;
        tick();
        hi_we = 1'b0; start = 1'b0;
        check("mt_with_start", {32'd0, hi}, {32'd0, 32'h1111});
        wait_done(0, cyc);
        check("mt_with_start_res", {hi, lo}, {32'd0, 32'd6});

        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hBEEF;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_both", {hi, lo}, {32'hBEEF, 32'hBEEF});

        // Asynchronous reset mid-iteration.
        saved = {hi, lo};
        launch(2'd3, 32'd1000, 32'd7);
        repeat (20) tick();
        check("pre_rst_hilo", {hi, lo}, saved);
        #2 rst = 1'b1;
        #1;
        check("async_rst_hilo", {hi, lo}, 64'd0);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        run_op("after_rst", 2'd3, 32'd1000, 32'd7, {32'd6, 32'd142});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
